// File: rtl/handshake_rr_arb.sv
// Round-robin arbiter: NUM_REQ valid/ready upstream channels feed a single
// registered downstream slot. It also keeps a saturating count of downstream transfers.
module handshake_rr_arb #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 8,
   parameter int ID_W    = 2
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      arb_en_i,
   input  logic [NUM_REQ-1:0]        up_valid_i,
   input  logic [NUM_REQ*DATA_W-1:0] up_data_i,
   output logic [NUM_REQ-1:0]        up_ready_o,
   output logic                      dn_valid_o,
   output logic [DATA_W-1:0]         dn_data_o,
   output logic [ID_W-1:0]           dn_id_o,
   input  logic                      dn_ready_i,
   output logic [15:0]               xfer_cnt_o
);

   logic              r_dn_valid;
   logic [DATA_W-1:0] r_dn_data;
   logic [ID_W-1:0]   r_dn_id;
   logic [ID_W-1:0]   r_ptr;
   logic [15:0]       r_xfer_cnt;

   logic              w_can_load;
   logic              w_found;
   logic [ID_W-1:0]   w_winner;
   logic [DATA_W-1:0] w_win_data;
   logic              w_grant;

   assign w_can_load = ~r_dn_valid | dn_ready_i;

   // Winner search: first valid requester after the last-granted index, wrapping.
   always_comb begin
      w_found    = 1'b0;
      w_winner   = '0;
      w_win_data = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         int j;
         j = int'(r_ptr) + i;
         if (j >= NUM_REQ) begin
            j = j - NUM_REQ;
         end else begin
            j = j;
         end
         if (!w_found && up_valid_i[j]) begin
            w_found    = 1'b1;
            w_winner   = ID_W'(j);
            w_win_data = up_data_i[j*DATA_W +: DATA_W];
         end else begin
            w_found    = w_found;
         end
      end
   end

   // Ready is held low while reset is asserted even though the slot looks empty.
   assign w_grant = rst_n & arb_en_i & w_can_load & w_found;

   // One-hot ready towards the current winner only.
   always_comb begin
      up_ready_o = '0;
      if (w_grant) begin
         up_ready_o[w_winner] = 1'b1;
      end else begin
         up_ready_o = '0;
      end
   end

   // Output slot and round-robin pointer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_dn_valid <= 1'b0;
         r_dn_data  <= '0;
         r_dn_id    <= '0;
         r_ptr      <= ID_W'(NUM_REQ - 1);
      end else if (w_grant) begin
         r_dn_valid <= 1'b1;
         r_dn_data  <= w_win_data;
         r_dn_id    <= w_winner;
         r_ptr      <= w_winner;
      end else if (dn_ready_i) begin
         r_dn_valid <= 1'b0;
      end
   end

   // Saturating downstream transfer counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_xfer_cnt <= 16'h0000;
      end else if (r_dn_valid && dn_ready_i && (r_xfer_cnt != 16'hFFFF)) begin
         r_xfer_cnt <= r_xfer_cnt + 16'h0001;
      end
   end

   assign dn_valid_o = r_dn_valid;
   assign dn_data_o  = r_dn_data;
   assign dn_id_o    = r_dn_id;
   assign xfer_cnt_o = r_xfer_cnt;

endmodule

// File: tb/tb_handshake_rr_arb.sv
// Directed bench for handshake_rr_arb (NUM_REQ=4, DATA_W=8) with
// hand-computed expected grants, payloads and counter values.
module tb_handshake_rr_arb;

   logic        clk;
   logic        rst_n;
   logic        arb_en_i;
   logic [3:0]  up_valid_i;
   logic [31:0] up_data_i;
   logic [3:0]  up_ready_o;
   logic        dn_valid_o;
   logic [7:0]  dn_data_o;
   logic [1:0]  dn_id_o;
   logic        dn_ready_i;
   logic [15:0] xfer_cnt_o;

   int n_total;
   int n_bad;

   handshake_rr_arb #(.NUM_REQ(4), .DATA_W(8), .ID_W(2)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .arb_en_i   (arb_en_i),
      .up_valid_i (up_valid_i),
      .up_data_i  (up_data_i),
      .up_ready_o (up_ready_o),
      .dn_valid_o (dn_valid_o),
      .dn_data_o  (dn_data_o),
      .dn_id_o    (dn_id_o),
      .dn_ready_i (dn_ready_i),
      .xfer_cnt_o (xfer_cnt_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_out(input string tag, input logic v, input logic [1:0] id, input logic [7:0] d);
      chk({tag, "_valid"}, {31'd0, dn_valid_o}, {31'd0, v});
      chk({tag, "_id"},    {30'd0, dn_id_o},    {30'd0, id});
      chk({tag, "_data"},  {24'd0, dn_data_o},  {24'd0, d});
   endtask

   task automatic chk_rdy(input string tag, input logic [3:0] exp);
      #1;
      chk(tag, {28'd0, up_ready_o}, {28'd0, exp});
   endtask

   initial begin
      logic [1:0] ids [5];
      logic [7:0] dat [5];
      logic [3:0] rdy [5];
      ids = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      dat = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA0};
      rdy = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      n_total    = 0;
      n_bad      = 0;
      rst_n      = 1'b0;
      arb_en_i   = 1'b1;
      dn_ready_i = 1'b1;
      up_valid_i = 4'b1111;
      up_data_i  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};

      // Reset state
      #12;
      chk("rst_ready", {28'd0, up_ready_o}, 32'd0);
      chk_out("rst", 1'b0, 2'd0, 8'h00);
      chk("rst_cnt", {16'd0, xfer_cnt_o}, 32'd0);
      rst_n = 1'b1;

      // Fairness sequence 0,1,2,3,0 with full throughput
      for (int k = 0; k < 5; k++) begin
         chk_rdy($sformatf("rr_ready%0d", k), rdy[k]);
         tick();
         chk_out($sformatf("rr%0d", k), 1'b1, ids[k], dat[k]);
      end
      chk("rr_cnt", {16'd0, xfer_cnt_o}, 32'd4);

      // Back-pressure hold of 8'h55
      up_valid_i = 4'b0010;
      up_data_i  = {8'hA3, 8'hA2, 8'h55, 8'hA0};
      chk_rdy("bp_load_ready", 4'b0010);
      tick();
      chk_out("bp_load", 1'b1, 2'd1, 8'h55);
      dn_ready_i = 1'b0;
      up_valid_i = 4'b1111;
      for (int k = 0; k < 3; k++) begin
         chk_rdy($sformatf("bp_ready%0d", k), 4'b0000);
         tick();
         chk_out($sformatf("bp_hold%0d", k), 1'b1, 2'd1, 8'h55);
      end
      dn_ready_i = 1'b1;
      chk_rdy("bp_release_ready", 4'b0100);
      tick();
      chk_out("bp_next", 1'b1, 2'd2, 8'hA2);
      chk("bp_cnt", {16'd0, xfer_cnt_o}, 32'd6);

      // Wrap-around from ptr=1
      up_valid_i = 4'b0010;
      tick();
      chk_out("wrap_setup", 1'b1, 2'd1, 8'h55);
      up_valid_i = 4'b0001;
      chk_rdy("wrap_ready0", 4'b0001);
      tick();
      chk_out("wrap0", 1'b1, 2'd0, 8'hA0);
      up_valid_i = 4'b1001;
      chk_rdy("wrap_ready3", 4'b1000);
      tick();
      chk_out("wrap3", 1'b1, 2'd3, 8'hA3);
      chk_rdy("wrap_ready0b", 4'b0001);
      tick();
      chk_out("wrap0b", 1'b1, 2'd0, 8'hA0);
      chk("wrap_cnt", {16'd0, xfer_cnt_o}, 32'd10);

      // Arbitration disabled: slot drains, pointer held
      arb_en_i   = 1'b0;
      up_valid_i = 4'b1111;
      chk_rdy("dis_ready", 4'b0000);
      tick();
      chk("dis_drain", {31'd0, dn_valid_o}, 32'd0);
      chk_rdy("dis_ready2", 4'b0000);
      tick();
      chk("dis_idle", {31'd0, dn_valid_o}, 32'd0);
      arb_en_i = 1'b1;
      chk_rdy("en_ready", 4'b0010);
      tick();
      chk_out("en_resume", 1'b1, 2'd1, 8'h55);
      chk("en_cnt", {16'd0, xfer_cnt_o}, 32'd11);

      // Asynchronous reset while the slot is full
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_valid", {31'd0, dn_valid_o}, 32'd0);
      chk("arst_cnt", {16'd0, xfer_cnt_o}, 32'd0);
      chk("arst_ready", {28'd0, up_ready_o}, 32'd0);
      #1;
      rst_n = 1'b1;
      chk_rdy("arst_first_ready", 4'b0001);
      tick();
      chk_out("arst_first", 1'b1, 2'd0, 8'hA0);

      // Counter saturation
      repeat (65534) tick();
      chk("sat_fffe", {16'd0, xfer_cnt_o}, 32'h0000FFFE);
      chk("sat_id", {30'd0, dn_id_o}, {30'd0, 2'd2});
      repeat (3) tick();
      chk("sat_ffff", {16'd0, xfer_cnt_o}, 32'h0000FFFF);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
